// File: rtl/roc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : roc_pkg
// Purpose  : Shared types, default AER addresses and parameter checks for the
//            rank-order-coding lane encoder.
// Revision : 1.0 - initial release
// ============================================================================
package roc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SCAN     = 3'd2,
        ST_EMIT     = 3'd3,
        ST_EOI      = 3'd4,
        ST_FINISH   = 3'd5
    } roc_state_t;

    localparam int         C_DEF_AER_BITS      = 10;
    localparam logic [9:0] C_DEF_PREAMBLE_ADDR = 10'h1FF;
    localparam logic [9:0] C_DEF_EOI_ADDR      = 10'h1FE;

    // Control addresses must not alias any pixel index.
    function automatic bit addr_outside_image(input longint unsigned addr,
                                              input longint unsigned image_size);
        return addr >= image_size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/roc_lane_picker.sv
`default_nettype none
// ============================================================================
// Module   : roc_lane_picker
// Purpose  : Combinational masked priority encoder; reports the lowest set lane.
// Revision : 1.0 - initial release
// ============================================================================
module roc_lane_picker #(
    parameter int LANES  = 4,
    parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LANES-1:0]  MATCH,
    output logic              FOUND,
    output logic [LANE_W-1:0] LANE
);

    always_comb begin
        FOUND = |MATCH;
        LANE  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (MATCH[i]) LANE = LANE_W'(i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/roc_lane_encoder.sv
`default_nettype none
// ============================================================================
// Module   : roc_lane_encoder
// Purpose  : Rank-order spike encoder emitting AER pixel events by descending
//            intensity, LANES pixels compared per cycle.
//            Optional macro ROC_EOI_MARKER_EN appends an EOI_ADDR event.
// Revision : 1.0 - initial release
// ============================================================================
module roc_lane_encoder
    import roc_pkg::*;
#(
    parameter int                    IMAGE_SIZE      = 256,
    parameter int                    PIXEL_BITS      = 8,
    parameter int                    LANES           = 4,
    parameter int                    AER_BITS        = C_DEF_AER_BITS,
    parameter int                    PREAMBLE_EVENTS = 2,
    parameter logic [AER_BITS-1:0]   PREAMBLE_ADDR   = AER_BITS'(C_DEF_PREAMBLE_ADDR),
    parameter logic [AER_BITS-1:0]   EOI_ADDR        = AER_BITS'(C_DEF_EOI_ADDR)
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [PIXEL_BITS-1:0]           IMAGE [IMAGE_SIZE],
    input  logic                            NEW_IMAGE,
    input  logic [PIXEL_BITS-1:0]           THRESHOLD,
    input  logic [$clog2(IMAGE_SIZE):0]     MAX_SPIKES,
    input  logic                            ABORT,
    output logic [AER_BITS-1:0]             AER_ADDR,
    output logic                            AER_VALID,
    input  logic                            AER_READY,
    output logic                            ENCODER_RDY,
    output logic                            DONE,
    output logic [$clog2(IMAGE_SIZE):0]     SPIKE_COUNT
);

    localparam int c_IDX_W   = $clog2(IMAGE_SIZE);
    localparam int c_CNT_W   = c_IDX_W + 1;
    localparam int c_GROUPS  = IMAGE_SIZE / LANES;
    localparam int c_GRP_W   = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
    localparam int c_LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_LANE_SH = $clog2(LANES);
    localparam int c_PRE_W   = (PREAMBLE_EVENTS > 1) ? $clog2(PREAMBLE_EVENTS) : 1;

`ifdef ROC_EOI_MARKER_EN
    localparam roc_state_t c_FIN_STATE = ST_EOI;
`else
    localparam roc_state_t c_FIN_STATE = ST_FINISH;
`endif

    if (!addr_outside_image(PREAMBLE_ADDR, IMAGE_SIZE)) begin : g_chk_preamble_addr
        $error("PREAMBLE_ADDR must not alias a pixel index");
    end
    if (!addr_outside_image(EOI_ADDR, IMAGE_SIZE)) begin : g_chk_eoi_addr
        $error("EOI_ADDR must not alias a pixel index");
    end
    if (AER_BITS <= c_IDX_W || (IMAGE_SIZE % LANES) != 0) begin : g_chk_geometry
        $error("AER_BITS too narrow or IMAGE_SIZE not a multiple of LANES");
    end

    roc_state_t              r_state;
    roc_state_t              w_next;
    logic [PIXEL_BITS-1:0]   r_level;
    logic [PIXEL_BITS-1:0]   r_thresh;
    logic [c_GRP_W-1:0]      r_group;
    logic [LANES-1:0]        r_mask;
    logic [c_LANE_W-1:0]     r_lane;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_CNT_W-1:0]      r_max;
    logic [c_PRE_W-1:0]      r_pre_cnt;
    logic [AER_BITS-1:0]     r_addr;
    logic                    r_abort;

    logic [LANES-1:0]        w_match;
    logic                    w_found;
    logic [c_LANE_W-1:0]     w_lane;
    logic [c_IDX_W-1:0]      w_base;
    logic [c_IDX_W-1:0]      w_pix_idx;
    logic [c_CNT_W-1:0]      w_count_inc;
    logic                    w_hs;
    logic                    w_abort;
    logic                    w_last_group;
    logic                    w_last_level;
    logic                    w_last_pre;
    logic                    w_budget_hit;

    assign w_base       = c_IDX_W'(r_group) << c_LANE_SH;
    assign w_pix_idx    = w_base | c_IDX_W'(w_lane);
    assign w_count_inc  = r_count + c_CNT_W'(1);
    assign w_hs         = AER_VALID && AER_READY;
    assign w_abort      = r_abort || ABORT;
    assign w_last_group = (r_group == c_GRP_W'(c_GROUPS - 1));
    assign w_last_level = (r_level == r_thresh);
    assign w_last_pre   = (r_pre_cnt == c_PRE_W'(PREAMBLE_EVENTS - 1));
    assign w_budget_hit = (r_max != '0) && (w_count_inc == r_max);

    always_comb begin
        w_match = '0;
        for (int i = 0; i < LANES; i++) begin
            w_match[i] = r_mask[i] && (IMAGE[w_base + c_IDX_W'(i)] == r_level);
        end
    end

    roc_lane_picker #(
        .LANES  (LANES),
        .LANE_W (c_LANE_W)
    ) u_picker (
        .MATCH (w_match),
        .FOUND (w_found),
        .LANE  (w_lane)
    );

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // An event already on the bus always completes before abort takes effect.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (NEW_IMAGE) w_next = (PREAMBLE_EVENTS != 0) ? ST_PREAMBLE : ST_SCAN;
            ST_PREAMBLE: if (w_hs) begin
                             if (w_abort)         w_next = c_FIN_STATE;
                             else if (w_last_pre) w_next = ST_SCAN;
                         end
            ST_SCAN:     if (w_abort)                           w_next = c_FIN_STATE;
                         else if (w_found)                      w_next = ST_EMIT;
                         else if (w_last_group && w_last_level) w_next = c_FIN_STATE;
            ST_EMIT:     if (w_hs) w_next = (w_abort || w_budget_hit) ? c_FIN_STATE : ST_SCAN;
`ifdef ROC_EOI_MARKER_EN
            ST_EOI:      if (w_hs) w_next = ST_FINISH;
`endif
            ST_FINISH:   w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        AER_VALID   = 1'b0;
        ENCODER_RDY = 1'b0;
        DONE        = 1'b0;
        case (r_state)
            ST_IDLE:              ENCODER_RDY = 1'b1;
            ST_PREAMBLE, ST_EMIT: AER_VALID   = 1'b1;
`ifdef ROC_EOI_MARKER_EN
            ST_EOI:               AER_VALID   = 1'b1;
`endif
            ST_FINISH:            DONE        = 1'b1;
            default:              ;
        endcase
    end

    assign AER_ADDR    = r_addr;
    assign SPIKE_COUNT = r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_level   <= '1;
            r_thresh  <= '0;
            r_group   <= '0;
            r_mask    <= '1;
            r_lane    <= '0;
            r_count   <= '0;
            r_max     <= '0;
            r_pre_cnt <= '0;
            r_addr    <= '0;
            r_abort   <= 1'b0;
        end else begin
            if (r_state != ST_IDLE && ABORT) r_abort <= 1'b1;
            case (r_state)
                ST_IDLE: if (NEW_IMAGE) begin
                    r_count   <= '0;
                    r_level   <= '1;
                    r_group   <= '0;
                    r_thresh  <= THRESHOLD;
                    r_max     <= MAX_SPIKES;
                    r_mask    <= '1;
                    r_pre_cnt <= '0;
                    r_abort   <= 1'b0;
                    r_addr    <= PREAMBLE_ADDR;
                end
                ST_PREAMBLE: if (w_hs) r_pre_cnt <= r_pre_cnt + c_PRE_W'(1);
                ST_SCAN: begin
                    if (w_next == ST_EMIT) begin
                        r_addr <= AER_BITS'(w_pix_idx);
                        r_lane <= w_lane;
                    end else if (w_next != c_FIN_STATE) begin
                        r_mask <= '1;
                        if (w_last_group) begin
                            r_group <= '0;
                            r_level <= r_level - PIXEL_BITS'(1);
                        end else begin
                            r_group <= r_group + c_GRP_W'(1);
                        end
                    end
                end
                ST_EMIT: if (w_hs) begin
                    r_mask[r_lane] <= 1'b0;
                    r_count        <= w_count_inc;
                end
                default: ;
            endcase
`ifdef ROC_EOI_MARKER_EN
            if (r_state != ST_EOI && w_next == ST_EOI) r_addr <= EOI_ADDR;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_roc_lane_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_roc_lane_encoder
// Purpose  : Scoreboard bench for roc_lane_encoder on an 8-pixel, 4-lane image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_roc_lane_encoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] IMAGE [8];
    logic       NEW_IMAGE = 1'b0;
    logic [7:0] THRESHOLD = 8'd0;
    logic [3:0] MAX_SPIKES = 4'd0;
    logic       ABORT = 1'b0;
    logic       AER_READY = 1'b1;
    logic [9:0] AER_ADDR;
    logic       AER_VALID;
    logic       ENCODER_RDY;
    logic       DONE;
    logic [3:0] SPIKE_COUNT;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_hs  = -10;
    int done_cyc = -10;
    logic [9:0] exp_q [$];
    logic       hold_prev = 1'b0;
    logic [9:0] prev_addr = '0;
    logic [9:0] full_seq [10];
    localparam logic [9:0] NONE = 10'h3FF;

    roc_lane_encoder #(
        .IMAGE_SIZE      (8),
        .PIXEL_BITS      (8),
        .LANES           (4),
        .AER_BITS        (10),
        .PREAMBLE_EVENTS (2),
        .PREAMBLE_ADDR   (10'h1FF),
        .EOI_ADDR        (10'h1FE)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IMAGE       (IMAGE),
        .NEW_IMAGE   (NEW_IMAGE),
        .THRESHOLD   (THRESHOLD),
        .MAX_SPIKES  (MAX_SPIKES),
        .ABORT       (ABORT),
        .AER_ADDR    (AER_ADDR),
        .AER_VALID   (AER_VALID),
        .AER_READY   (AER_READY),
        .ENCODER_RDY (ENCODER_RDY),
        .DONE        (DONE),
        .SPIKE_COUNT (SPIKE_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_first(input int n, input bit eoi);
        for (int i = 0; i < n; i++) exp_q.push_back(full_seq[i]);
`ifdef ROC_EOI_MARKER_EN
        if (eoi) exp_q.push_back(10'h1FE);
`else
        if (eoi) exp_q.push_back(NONE);
        if (eoi) void'(exp_q.pop_back());
`endif
    endtask

    // Monitor: mid-cycle sampling of handshakes, stalls and DONE.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            if (hold_prev) begin
                chk("hold_valid", 32'(AER_VALID), 32'd1);
                chk("hold_addr", 32'(AER_ADDR), 32'(prev_addr));
            end
            hold_prev = AER_VALID && !AER_READY && !RST;
            prev_addr = AER_ADDR;
            if (AER_VALID && AER_READY && !RST) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_event actual=%0h required=none", AER_ADDR);
                end else begin
                    chk("aer_addr", 32'(AER_ADDR), 32'(exp_q.pop_front()));
                end
                last_hs = cyc;
            end
            if (DONE) done_cyc = cyc;
        end
    end

    task automatic run_image(input string tag, input logic [7:0] th, input logic [3:0] mx,
                             input logic [9:0] stall_a, input int stall_n,
                             input logic [9:0] abort_a, input logic [9:0] rst_a,
                             input int exp_cnt, input bit fast);
        int stalls = 0;
        bit aborted = 0;
        bit done_seen = 0;
        THRESHOLD  = th;
        MAX_SPIKES = mx;
        AER_READY  = 1'b1;
        NEW_IMAGE  = 1'b1;
        @(posedge CLK); #1;
        NEW_IMAGE = 1'b0;
        chk({tag, "_start_valid"}, 32'(AER_VALID), 32'd1);
        chk({tag, "_start_rdy"}, 32'(ENCODER_RDY), 32'd0);
        chk({tag, "_start_count"}, 32'(SPIKE_COUNT), 32'd0);
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            AER_READY = 1'b1;
            ABORT     = 1'b0;
            NEW_IMAGE = 1'b0;
            if (DONE) begin
                done_seen = 1;
            end else if (AER_VALID && AER_ADDR == rst_a) begin
                AER_READY = 1'b0;
                RST = 1'b1;
                @(posedge CLK); #1;
                RST = 1'b0;
                chk({tag, "_rst_valid"}, 32'(AER_VALID), 32'd0);
                chk({tag, "_rst_rdy"}, 32'(ENCODER_RDY), 32'd1);
                chk({tag, "_rst_count"}, 32'(SPIKE_COUNT), 32'd0);
                chk({tag, "_rst_pending"}, 32'(exp_q.size()), 32'd0);
                return;
            end else begin
                if (AER_VALID && AER_ADDR == stall_a && stalls < stall_n) begin
                    AER_READY = 1'b0;
                    stalls++;
                end
                if (AER_VALID && AER_ADDR == abort_a && !aborted) begin
                    ABORT     = 1'b1;
                    NEW_IMAGE = 1'b1;
                    aborted   = 1;
                end
                @(posedge CLK); #1;
            end
        end
        chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
        chk({tag, "_spike_count"}, 32'(SPIKE_COUNT), 32'(exp_cnt));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        @(negedge CLK);
`ifdef ROC_EOI_MARKER_EN
        fast = 1;
`endif
        if (fast) chk({tag, "_done_timing"}, 32'(done_cyc), 32'(last_hs + 1));
        @(posedge CLK); #1;
        chk({tag, "_idle_rdy"}, 32'(ENCODER_RDY), 32'd1);
        chk({tag, "_idle_done"}, 32'(DONE), 32'd0);
    endtask

    initial begin
        IMAGE = '{8'd3, 8'd200, 8'd200, 8'd0, 8'd255, 8'd7, 8'd7, 8'd3};
        full_seq = '{10'h1FF, 10'h1FF, 10'd4, 10'd1, 10'd2, 10'd5, 10'd6, 10'd0, 10'd7, 10'd3};

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_valid", 32'(AER_VALID), 32'd0);
        chk("reset_addr", 32'(AER_ADDR), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_count", 32'(SPIKE_COUNT), 32'd0);
        chk("reset_rdy", 32'(ENCODER_RDY), 32'd1);
        RST = 1'b0;
        @(posedge CLK); #1;

        push_first(10, 1);
        run_image("full", 8'd0, 4'd0, NONE, 0, NONE, NONE, 8, 0);

        push_first(7, 1);
        run_image("thresh7", 8'd7, 4'd0, NONE, 0, NONE, NONE, 5, 0);

        push_first(4, 1);
        run_image("budget2", 8'd0, 4'd2, NONE, 0, NONE, NONE, 2, 1);

        push_first(10, 1);
        run_image("stall", 8'd0, 4'd0, 10'd1, 5, NONE, NONE, 8, 0);

        push_first(5, 1);
        run_image("abort", 8'd0, 4'd0, 10'd2, 2, 10'd2, NONE, 3, 1);

        push_first(4, 0);
        run_image("reset_mid", 8'd0, 4'd0, NONE, 0, NONE, 10'd2, 0, 0);

        push_first(10, 1);
        run_image("restart", 8'd0, 4'd0, NONE, 0, NONE, NONE, 8, 0);

        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/roc_lane_encoder.md
# roc_lane_encoder

Parametrised rank-order-coding (ROC) spike encoder sitting between the image input and the AER input controller of the SNN core. On a new image it first emits an AER reset preamble. It then emits pixel indices in descending-intensity order, ascending index within one intensity level. Each cycle it compares LANES pixels, and it adds a valid/ready AER handshake, an intensity threshold, a spike budget and abort.

## Interface
- IMAGE_SIZE, 256: pixels per image; power of 2, multiple of LANES.
- PIXEL_BITS, 8: pixel width; levels 0..2^PIXEL_BITS-1.
- LANES, 4: pixels compared per cycle; power of 2, ≤ IMAGE_SIZE.
- AER_BITS, 10: AER address width; must exceed $clog2(IMAGE_SIZE).
- PREAMBLE_EVENTS, 2: reset events sent before pixel events; 0 allowed.
- PREAMBLE_ADDR, 10'h1FF: preamble event address; must be ≥ IMAGE_SIZE (elaboration check).
- EOI_ADDR, 10'h1FE: end-of-image address; must be ≥ IMAGE_SIZE; used only with ROC_EOI_MARKER_EN.
- CLK  in  1  clock.
- RST  in  1  reset. One clock; reset is synchronous and active-high.
- IMAGE  in  PIXEL_BITS × IMAGE_SIZE  unpacked pixel array; must stay stable from accepted NEW_IMAGE until DONE.
- NEW_IMAGE  in  1  start; accepted only in IDLE, ignored otherwise.
- THRESHOLD  in  PIXEL_BITS  lowest level that is emitted; latched at start.
- MAX_SPIKES  in  $clog2(IMAGE_SIZE)+1  pixel-event budget, 0 = unlimited; latched at start.
- ABORT  in  1  stop encoding, e.g. when inference is ready.
- AER_ADDR  out  AER_BITS  event address.
- AER_VALID  out  1  event valid.
- AER_READY  in  1  AER controller accepts the event.
- ENCODER_RDY  out  1  high in IDLE.
- DONE  out  1  one-cycle pulse on return to IDLE.
- SPIKE_COUNT  out  $clog2(IMAGE_SIZE)+1  pixel events sent for the current or last image.

## Operation
- States: IDLE, PREAMBLE, SCAN, EMIT, EOI, FINISH.
- IDLE → PREAMBLE on NEW_IMAGE. The start edge clears SPIKE_COUNT, sets level = 2^PIXEL_BITS-1 and group = 0, latches THRESHOLD and MAX_SPIKES, and loads the lane mask to all ones.
- PREAMBLE: sends PREAMBLE_EVENTS events at PREAMBLE_ADDR, one handshake each, then goes to SCAN. With PREAMBLE_EVENTS = 0 it goes straight to SCAN.
- SCAN: match = mask & {IMAGE[group*LANES+i] == level}.
  - Match nonzero: pick the lowest set lane, latch its address as zero-extended group*LANES+lane, go to EMIT.
  - Match zero: reload mask to all ones and advance group.
  - After the last group: if level == THRESHOLD, finish; else level-1 and group 0.
- EMIT: AER_VALID high. On handshake, clear the picked mask bit, SPIKE_COUNT+1, return to SCAN (same group).
- Finish causes: level exhausted; SPIKE_COUNT reaching a nonzero MAX_SPIKES (checked after the handshake); ABORT.
- ABORT is sticky until IDLE. An event in flight (AER_VALID high) always completes its handshake. ABORT then finishes at the next PREAMBLE/SCAN boundary, with no further preamble or pixel events.
- Finish → EOI if the macro is defined, else FINISH. EOI sends one event at EOI_ADDR, then FINISH. FINISH pulses DONE, then IDLE.
- Level arithmetic is unsigned. THRESHOLD = 0 scans down to level 0 with no wrap. THRESHOLD = max scans only level max.

## Timing
- Reset values: AER_VALID 0, AER_ADDR 0, DONE 0, SPIKE_COUNT 0, ENCODER_RDY 1 (state IDLE). RST mid-operation returns to IDLE at the next edge with no partial event.
- NEW_IMAGE at edge n → AER_VALID high from cycle n+1 (first preamble event).
- AER_VALID, once high, stays high with AER_ADDR stable until the AER_READY handshake. Valid does not depend combinationally on ready.
- Handshake at edge k → next event valid no earlier than k+1, with one SCAN cycle per group.
- Worst-case scan: 2^PIXEL_BITS × IMAGE_SIZE/LANES SCAN cycles plus 2 cycles per event.
- DONE pulses in the cycle after the final handshake; ENCODER_RDY rises the cycle after that.

## Configuration
- ROC_EOI_MARKER_EN defined: every termination, including ABORT, emits one EOI_ADDR event before DONE.
- ROC_EOI_MARKER_EN undefined: no EOI state logic; DONE follows the last event directly; EOI_ADDR is ignored.

## Structure
- Package roc_pkg holds: roc_state_t enum, address-range check function, default AER constants (PREAMBLE_ADDR/EOI_ADDR defaults).
- Sub-module roc_lane_picker: combinational LANES-wide masked priority encoder, returning found and lane index.

## Test plan
- IMAGE_SIZE 8, LANES 4, pixels [3,200,200,0,255,7,7,3], THRESHOLD 0, AER_READY 1 → addresses 1FF,1FF,4,1,2,5,6,0,7,3; SPIKE_COUNT 8; one DONE pulse. With the macro, 1FE follows 3.
- Same image, THRESHOLD 7 → 1FF,1FF,4,1,2,5,6; SPIKE_COUNT 5.
- Same image, MAX_SPIKES 2 → 1FF,1FF,4,1 then DONE; SPIKE_COUNT 2.
- AER_READY low for 5 cycles while address 1 is valid → AER_VALID held, AER_ADDR stable at 1, no event lost or duplicated.
- ABORT pulsed while address 2 is pending → 2 completes, then DONE (with the macro, 1FE first); NEW_IMAGE during busy ignored.
- RST asserted mid-scan → next cycle AER_VALID 0, ENCODER_RDY 1, SPIKE_COUNT 0; a following NEW_IMAGE restarts with the preamble.
